// File: rtl/dram_cmd_timer.sv
// dram_cmd_timer: per-bank DRAM command timing controller that stalls, issues or drops scheduler commands.
// Optional refresh engine enabled by defining DRAM_REFRESH_EN.
module dram_cmd_timer #(
    parameter int BANK_GROUPS        = 8,
    parameter int BANKS_PER_GROUP    = 8,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int DATA_WIDTH         = 512,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int RAS_LATENCY        = 12,
    parameter int CCD_LATENCY        = 2,
    parameter int REFRESH_INTERVAL   = 780,
    parameter int REFRESH_LATENCY    = 26
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               cmd_valid_in,
    input  logic [2:0]                         cmd_in,
    input  logic [$clog2(BANK_GROUPS)-1:0]     bank_group_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0] bank_in,
    input  logic [ROW_BITS-1:0]                row_in,
    input  logic [COL_BITS-1:0]                col_in,
    input  logic [DATA_WIDTH-1:0]              val_in,
    output logic                               cmd_ready_out,
    output logic                               dram_valid_out,
    output logic [2:0]                         dram_cmd_out,
    output logic [$clog2(BANK_GROUPS)-1:0]     dram_bg_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] dram_bank_out,
    output logic [ROW_BITS-1:0]                dram_row_out,
    output logic [COL_BITS-1:0]                dram_col_out,
    output logic [DATA_WIDTH-1:0]              dram_val_out,
    output logic                               err_out
);
    localparam int NB  = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BW  = $clog2(NB);
    localparam int BGW = $clog2(BANK_GROUPS);
    localparam int BKW = $clog2(BANKS_PER_GROUP);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXL = max2(max2(max2(ACTIVATION_LATENCY, PRECHARGE_LATENCY),
                                    max2(RAS_LATENCY, CCD_LATENCY)), REFRESH_LATENCY);
    localparam int CW = $clog2(MAXL + 1);
    // Counters load latency-1 so they reach zero exactly latency cycles after the accepting cycle.
    localparam logic [CW-1:0] ACT_LD = CW'(ACTIVATION_LATENCY - 1);
    localparam logic [CW-1:0] PRE_LD = CW'(PRECHARGE_LATENCY - 1);
    localparam logic [CW-1:0] RAS_LD = CW'(RAS_LATENCY - 1);
    localparam logic [CW-1:0] CCD_LD = CW'(CCD_LATENCY - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OPENING = 2'd1;
    localparam logic [1:0] ST_OPEN    = 2'd2;
    localparam logic [1:0] ST_CLOSING = 2'd3;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_PRE = 3'd2;
    localparam logic [2:0] C_RD  = 3'd3;
    localparam logic [2:0] C_WR  = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    logic [1:0]            st_q   [NB];
    logic [1:0]            st_d   [NB];
    logic [ROW_BITS-1:0]   row_q  [NB];
    logic [ROW_BITS-1:0]   row_d  [NB];
    logic [CW-1:0]         tcnt_q [NB];
    logic [CW-1:0]         tcnt_d [NB];
    logic [CW-1:0]         ras_q  [NB];
    logic [CW-1:0]         ras_d  [NB];
    logic [CW-1:0]         ccd_q, ccd_d;
    logic                  dram_valid_q, dram_valid_d;
    logic [2:0]            dram_cmd_q, dram_cmd_d;
    logic [BGW-1:0]        dram_bg_q, dram_bg_d;
    logic [BKW-1:0]        dram_bank_q, dram_bank_d;
    logic [ROW_BITS-1:0]   dram_row_q, dram_row_d;
    logic [COL_BITS-1:0]   dram_col_q, dram_col_d;
    logic [DATA_WIDTH-1:0] dram_val_q, dram_val_d;
    logic                  err_q, err_d;
    logic [BW-1:0]         bidx;
    logic                  is_act, is_pre, is_rw, is_open, legal, time_ok, issue;
    logic                  ref_go, act_block;

    always_comb begin
        bidx          = BW'(int'(bank_group_in) * BANKS_PER_GROUP + int'(bank_in));
        is_act        = cmd_in == C_ACT;
        is_pre        = cmd_in == C_PRE;
        is_rw         = cmd_in == C_RD || cmd_in == C_WR;
        is_open       = st_q[bidx] == ST_OPEN || st_q[bidx] == ST_OPENING;
        legal         = cmd_in == C_NOP || (is_act && !is_open) || (is_pre && is_open) ||
                        (is_rw && is_open && row_in == row_q[bidx]);
        time_ok       = is_act ? (tcnt_q[bidx] == '0 && !act_block) :
                        is_pre ? ras_q[bidx] == '0 :
                        is_rw  ? (tcnt_q[bidx] == '0 && ccd_q == '0) : 1'b1;
        cmd_ready_out = !cmd_valid_in || !legal || time_ok;
        issue         = cmd_valid_in && legal && time_ok && cmd_in != C_NOP;
        err_d         = cmd_valid_in && !legal;
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            tcnt_d[b] = (tcnt_q[b] == '0) ? '0 : tcnt_q[b] - CW'(1);
            ras_d[b]  = (ras_q[b] == '0) ? '0 : ras_q[b] - CW'(1);
            row_d[b]  = row_q[b];
            st_d[b]   = (st_q[b] == ST_OPENING && tcnt_q[b] == '0) ? ST_OPEN :
                        (st_q[b] == ST_CLOSING && tcnt_q[b] == '0) ? ST_IDLE : st_q[b];
        end
        ccd_d = (ccd_q == '0) ? '0 : ccd_q - CW'(1);
        if (issue && is_act) begin
            st_d[bidx]   = ST_OPENING;
            row_d[bidx]  = row_in;
            tcnt_d[bidx] = ACT_LD;
            ras_d[bidx]  = RAS_LD;
        end
        if (issue && is_pre) begin
            st_d[bidx]   = ST_CLOSING;
            tcnt_d[bidx] = PRE_LD;
        end
        if (issue && is_rw)
            ccd_d = CCD_LD;
        dram_valid_d = issue || ref_go;
        dram_cmd_d   = issue ? cmd_in : ref_go ? C_REF : dram_cmd_q;
        dram_bg_d    = issue ? bank_group_in : dram_bg_q;
        dram_bank_d  = issue ? bank_in : dram_bank_q;
        dram_row_d   = issue ? row_in : dram_row_q;
        dram_col_d   = issue ? col_in : dram_col_q;
        dram_val_d   = issue ? val_in : dram_val_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int b = 0; b < NB; b++) begin
                st_q[b]   <= ST_IDLE;
                row_q[b]  <= '0;
                tcnt_q[b] <= '0;
                ras_q[b]  <= '0;
            end
            ccd_q        <= '0;
            dram_valid_q <= 1'b0;
            dram_cmd_q   <= '0;
            dram_bg_q    <= '0;
            dram_bank_q  <= '0;
            dram_row_q   <= '0;
            dram_col_q   <= '0;
            dram_val_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            st_q         <= st_d;
            row_q        <= row_d;
            tcnt_q       <= tcnt_d;
            ras_q        <= ras_d;
            ccd_q        <= ccd_d;
            dram_valid_q <= dram_valid_d;
            dram_cmd_q   <= dram_cmd_d;
            dram_bg_q    <= dram_bg_d;
            dram_bank_q  <= dram_bank_d;
            dram_row_q   <= dram_row_d;
            dram_col_q   <= dram_col_d;
            dram_val_q   <= dram_val_d;
            err_q        <= err_d;
        end
    end

`ifdef DRAM_REFRESH_EN
    localparam int            RIW    = $clog2(REFRESH_INTERVAL);
    localparam logic [CW-1:0] REF_LD = CW'(REFRESH_LATENCY - 1);

    logic [RIW-1:0] rint_q, rint_d;
    logic [CW-1:0]  rfc_q, rfc_d;
    logic           due_q, due_d, all_idle;

    // REF only goes out on a cycle with no scheduler issue, so the bus carries one command per cycle.
    always_comb begin
        all_idle = 1'b1;
        for (int b = 0; b < NB; b++)
            all_idle = all_idle && st_q[b] == ST_IDLE;
        ref_go    = due_q && all_idle && !issue;
        act_block = due_q || rfc_q != '0;
        rint_d    = (rint_q == RIW'(REFRESH_INTERVAL - 1)) ? '0 : rint_q + RIW'(1);
        due_d     = (rint_q == RIW'(REFRESH_INTERVAL - 1)) || (due_q && !ref_go);
        rfc_d     = ref_go ? REF_LD : (rfc_q == '0) ? '0 : rfc_q - CW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rint_q <= '0;
            rfc_q  <= '0;
            due_q  <= 1'b0;
        end else begin
            rint_q <= rint_d;
            rfc_q  <= rfc_d;
            due_q  <= due_d;
        end
    end
`else
    assign ref_go    = 1'b0;
    assign act_block = 1'b0;
`endif

    assign dram_valid_out = dram_valid_q;
    assign dram_cmd_out   = dram_cmd_q;
    assign dram_bg_out    = dram_bg_q;
    assign dram_bank_out  = dram_bank_q;
    assign dram_row_out   = dram_row_q;
    assign dram_col_out   = dram_col_q;
    assign dram_val_out   = dram_val_q;
    assign err_out        = err_q;
endmodule
